// File: rtl/controlador_secuencia.sv
// Simon-style sequence controller: grows a random cell sequence,
// replays it as timed flashes and checks the player's presses.
module controlador_secuencia #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int T_ON    = 12500000,
  parameter int T_OFF   = 6250000,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iniciar,
  input  logic [3:0]       posicion,
  input  logic             boton_valido,
  input  logic [3:0]       boton_pos,
  output logic             pedir,
  output logic             mostrar,
  output logic [3:0]       celda,
  output logic [LEN_W-1:0] nivel,
  output logic             esperando,
  output logic             acierto,
  output logic             error,
  output logic             fin
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAXL   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_FIN = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] OF_FIN = CNT_W'(T_OFF - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PEDIR,
    S_ESPERA,
    S_CAPTURA,
    S_ON,
    S_OFF,
    S_ENTRADA,
    S_ACIERTO,
    S_ERROR,
    S_GANADO
  } state_t;

  state_t state, state_n;

  logic [3:0]       mem [DEPTH];
  logic [LEN_W-1:0] idx, idx_n;
  logic [LEN_W-1:0] nivel_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0]       celda_n;
  logic [3:0]       actual;
  logic             ultimo;

  assign actual = mem[idx[AW-1:0]];
  assign ultimo = (idx + ONE_L) == nivel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      nivel     <= '0;
      timer     <= '0;
      celda     <= '0;
      pedir     <= 1'b0;
      mostrar   <= 1'b0;
      esperando <= 1'b0;
      acierto   <= 1'b0;
      error     <= 1'b0;
      fin       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      nivel     <= nivel_n;
      timer     <= timer_n;
      celda     <= celda_n;
      pedir     <= state_n == S_PEDIR;
      mostrar   <= state_n == S_ON;
      esperando <= state_n == S_ENTRADA;
      acierto   <= state_n == S_ACIERTO;
      error     <= state_n == S_ERROR;
      fin       <= state_n == S_GANADO;
    end
  end

  // sequence storage survives reset on purpose
  always_ff @(posedge clk) begin
    if (!rst && state == S_CAPTURA)
      mem[nivel[AW-1:0]] <= posicion;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    nivel_n = nivel;
    timer_n = timer;
    unique case (state)
      S_IDLE, S_GANADO: begin
        if (iniciar) begin
          nivel_n = '0;
          state_n = S_PEDIR;
        end
      end
      S_PEDIR:  state_n = S_ESPERA;
      S_ESPERA: state_n = S_CAPTURA;
      S_CAPTURA: begin
        nivel_n = nivel + ONE_L;
        idx_n   = '0;
        timer_n = '0;
        state_n = S_ON;
      end
      S_ON: begin
        if (timer == ON_FIN) begin
          timer_n = '0;
          state_n = S_OFF;
        end else begin
          timer_n = timer + ONE_C;
        end
      end
      S_OFF: begin
        if (timer == OF_FIN) begin
          timer_n = '0;
          if (ultimo) begin
            idx_n   = '0;
            state_n = S_ENTRADA;
          end else begin
            idx_n   = idx + ONE_L;
            state_n = S_ON;
          end
        end else begin
          timer_n = timer + ONE_C;
        end
      end
      S_ENTRADA: begin
        if (boton_valido) begin
          if (boton_pos != actual)
            state_n = S_ERROR;
          else if (ultimo)
            state_n = S_ACIERTO;
          else
            idx_n = idx + ONE_L;
        end
      end
      S_ACIERTO: state_n = (nivel == MAXL) ? S_GANADO : S_PEDIR;
      S_ERROR:   state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // the freshly captured cell is not in mem yet when entering the display
  always_comb begin
    celda_n = celda;
    if (state_n == S_ON && state != S_ON) begin
      if (state == S_CAPTURA && idx_n[AW-1:0] == nivel[AW-1:0])
        celda_n = posicion;
      else
        celda_n = mem[idx_n[AW-1:0]];
    end
    if (state_n == S_IDLE)
      celda_n = '0;
  end

endmodule

// File: tb/tb_controlador_secuencia.sv
// Bench for controlador_secuencia: vector table, directed corner
// sequences and random games checked against a queue-based game model.
module tb_controlador_secuencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int MAXL  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       iniciar;
  logic [3:0] posicion;
  logic       boton_valido;
  logic [3:0] boton_pos;
  logic       pedir;
  logic       mostrar;
  logic [3:0] celda;
  logic [4:0] nivel;
  logic       esperando;
  logic       acierto;
  logic       error;
  logic       fin;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] seq [$];

  controlador_secuencia #(
    .MAX_LEN(MAXL),
    .LEN_W  (5),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iniciar     (iniciar),
    .posicion    (posicion),
    .boton_valido(boton_valido),
    .boton_pos   (boton_pos),
    .pedir       (pedir),
    .mostrar     (mostrar),
    .celda       (celda),
    .nivel       (nivel),
    .esperando   (esperando),
    .acierto     (acierto),
    .error       (error),
    .fin         (fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ini;
    logic [3:0] pos;
    logic       bv;
    logic [3:0] bp;
    logic       pe;
    logic       mo;
    logic [3:0] ce;
    logic [4:0] ni;
    logic       es;
    logic       ac;
    logic       er;
    logic       fi;
  } vec_t;

  function automatic vec_t v(input int ini, pos, bv, bp,
                             input int pe, mo, ce, ni,
                             input int es, ac, er, fi);
    vec_t r;
    r.ini = (ini != 0);
    r.pos = 4'(pos);
    r.bv  = (bv != 0);
    r.bp  = 4'(bp);
    r.pe  = (pe != 0);
    r.mo  = (mo != 0);
    r.ce  = 4'(ce);
    r.ni  = 5'(ni);
    r.es  = (es != 0);
    r.ac  = (ac != 0);
    r.er  = (er != 0);
    r.fi  = (fi != 0);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // entry: current cycle should be the pedir cycle; exit: first ENTRADA cycle
  task automatic ronda(input logic [3:0] nueva);
    chk("pedir_on", 32'(pedir), 1);
    chk("nivel_pre", 32'(nivel), seq.size());
    tick();
    chk("pedir_off", 32'(pedir), 0);
    chk("mostrar_wait", 32'(mostrar), 0);
    tick();
    chk("pulses_capt", 32'({pedir, acierto, error, fin}), 0);
    posicion = nueva;
    tick();
    posicion = ~nueva;
    seq.push_back(nueva);
    chk("nivel_post", 32'(nivel), seq.size());
    foreach (seq[i]) begin
      for (int c = 0; c < T_ON; c++) begin
        chk("mostrar_on", 32'(mostrar), 1);
        chk("celda_on", 32'(celda), 32'(seq[i]));
        chk("esp_disp", 32'(esperando), 0);
        chk("pulses_disp", 32'({pedir, acierto, error, fin}), 0);
        boton_valido = 1'($urandom_range(0, 1));
        boton_pos    = 4'($urandom_range(0, 15));
        tick();
      end
      for (int c = 0; c < T_OFF; c++) begin
        chk("mostrar_off", 32'(mostrar), 0);
        chk("celda_off", 32'(celda), 32'(seq[i]));
        chk("esp_gap", 32'(esperando), 0);
        chk("pulses_gap", 32'({pedir, acierto, error, fin}), 0);
        boton_valido = 1'($urandom_range(0, 1));
        boton_pos    = 4'($urandom_range(0, 15));
        tick();
      end
    end
    boton_valido = 1'b0;
    chk("esperando", 32'(esperando), 1);
    chk("mostrar_in", 32'(mostrar), 0);
    chk("celda_in", 32'(celda), 32'(seq[seq.size()-1]));
  endtask

  // res: 0 wrong press (now IDLE), 1 round ok (now pedir), 2 won
  task automatic responder(input int widx, input logic [3:0] wval,
                           output int res);
    int gap;
    res = 1;
    for (int i = 0; i < seq.size(); i++) begin
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        iniciar = 1'($urandom_range(0, 1));
        tick();
        chk("esp_idle", 32'(esperando), 1);
        chk("nivel_idle", 32'(nivel), seq.size());
      end
      iniciar      = 1'b0;
      boton_valido = 1'b1;
      boton_pos    = (i == widx) ? wval : seq[i];
      tick();
      boton_valido = 1'b0;
      if (i == widx) begin
        chk("error_on", 32'(error), 1);
        chk("acierto_err", 32'(acierto), 0);
        chk("esp_err", 32'(esperando), 0);
        tick();
        chk("error_off", 32'(error), 0);
        chk("idle_outs", 32'({pedir, mostrar, esperando, acierto, fin}), 0);
        chk("idle_celda", 32'(celda), 0);
        chk("nivel_fail", 32'(nivel), seq.size());
        res = 0;
        return;
      end
      if (i == seq.size() - 1) begin
        chk("acierto_on", 32'(acierto), 1);
        chk("esp_ac", 32'(esperando), 0);
        chk("error_ac", 32'(error), 0);
        chk("pedir_ac", 32'(pedir), 0);
        tick();
        chk("acierto_off", 32'(acierto), 0);
        if (seq.size() == MAXL) begin
          chk("fin_on", 32'(fin), 1);
          chk("pedir_win", 32'(pedir), 0);
          res = 2;
        end else begin
          chk("fin_off", 32'(fin), 0);
        end
      end else begin
        chk("esp_mid", 32'(esperando), 1);
        chk("pulses_mid", 32'({acierto, error}), 0);
      end
    end
  endtask

  task automatic hold_fin(input int n);
    for (int k = 0; k < n; k++) begin
      boton_valido = 1'($urandom_range(0, 1));
      boton_pos    = 4'($urandom_range(0, 15));
      tick();
      chk("fin_hold", 32'(fin), 1);
      chk("nivel_win", 32'(nivel), MAXL);
      chk("pulses_win", 32'({pedir, mostrar, esperando, acierto, error}), 0);
    end
    boton_valido = 1'b0;
  endtask

  task automatic arrancar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    seq.delete();
    chk("start_fin", 32'(fin), 0);
    chk("start_nivel", 32'(nivel), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tab [11];
    int res;
    int w;
    logic [3:0] wv;

    // ini pos bv bp | pe mo ce ni es ac er fi
    tab[0]  = v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tab[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[2]  = v(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[3]  = v(0, 9, 1, 9, 0, 1, 9, 1, 0, 0, 0, 0);
    tab[4]  = v(0, 5, 1, 9, 0, 1, 9, 1, 0, 0, 0, 0);
    tab[5]  = v(0, 5, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0);
    tab[6]  = v(1, 5, 1, 2, 0, 1, 9, 1, 0, 0, 0, 0);
    tab[7]  = v(0, 5, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    tab[8]  = v(0, 5, 1, 9, 0, 0, 9, 1, 0, 0, 0, 0);
    tab[9]  = v(1, 5, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
    tab[10] = v(0, 5, 1, 9, 0, 0, 9, 1, 0, 1, 0, 0);

    rst          = 1'b1;
    iniciar      = 1'b0;
    posicion     = 4'd0;
    boton_valido = 1'b0;
    boton_pos    = 4'd0;
    tick();
    rst = 1'b0;
    chk("rst_outs", 32'({pedir, mostrar, esperando, acierto, error, fin}), 0);
    chk("rst_celda", 32'(celda), 0);
    chk("rst_nivel", 32'(nivel), 0);
    tick();
    chk("idle_quiet", 32'({pedir, mostrar, esperando}), 0);

    foreach (tab[i]) begin
      iniciar      = tab[i].ini;
      posicion     = tab[i].pos;
      boton_valido = tab[i].bv;
      boton_pos    = tab[i].bp;
      tick();
      chk($sformatf("v%0d_pedir", i), 32'(pedir), 32'(tab[i].pe));
      chk($sformatf("v%0d_mostrar", i), 32'(mostrar), 32'(tab[i].mo));
      chk($sformatf("v%0d_celda", i), 32'(celda), 32'(tab[i].ce));
      chk($sformatf("v%0d_nivel", i), 32'(nivel), 32'(tab[i].ni));
      chk($sformatf("v%0d_esp", i), 32'(esperando), 32'(tab[i].es));
      chk($sformatf("v%0d_acierto", i), 32'(acierto), 32'(tab[i].ac));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(tab[i].er));
      chk($sformatf("v%0d_fin", i), 32'(fin), 32'(tab[i].fi));
    end
    iniciar      = 1'b0;
    boton_valido = 1'b0;
    seq.delete();
    seq.push_back(4'd9);
    tick();

    // round 2 shows 9 then 3, round 3 wins the game
    ronda(4'd3);
    responder(-1, 4'd0, res);
    chk("r2_ok", 32'(res), 1);
    ronda(4'($urandom_range(0, 15)));
    responder(-1, 4'd0, res);
    chk("r3_win", 32'(res), 2);
    hold_fin(20);

    // restart from the won state, then fail at level 2 on the 2nd press
    arrancar();
    ronda(4'd9);
    responder(-1, 4'd0, res);
    chk("g2_r1", 32'(res), 1);
    ronda(4'd3);
    responder(1, 4'd5, res);
    chk("g2_err", 32'(res), 0);
    boton_valido = 1'b1;
    boton_pos    = 4'd9;
    tick();
    boton_valido = 1'b0;
    chk("stray_press", 32'({acierto, error, esperando, pedir}), 0);
    chk("stray_nivel", 32'(nivel), 2);

    // reset in the middle of the display
    arrancar();
    chk("pre_rst_pedir", 32'(pedir), 1);
    tick();
    tick();
    posicion = 4'd7;
    tick();
    chk("pre_rst_show", 32'({mostrar, celda}), 32'({1'b1, 4'd7}));
    boton_valido = 1'b1;
    boton_pos    = 4'd7;
    tick();
    boton_valido = 1'b0;
    tick();
    chk("pre_rst_pulse", 32'({acierto, error}), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mostrar", 32'(mostrar), 0);
    chk("rst_nivel2", 32'(nivel), 0);
    chk("rst_all", 32'({pedir, esperando, acierto, error, fin, celda}), 0);
    tick();
    chk("rst_no_pedir", 32'({pedir, mostrar}), 0);

    // random games against the queue model
    for (int g = 0; g < 10; g++) begin
      arrancar();
      res = 1;
      while (res == 1) begin
        ronda(4'($urandom_range(0, 15)));
        w = -1;
        wv = 4'd0;
        if ($urandom_range(0, 3) == 0) begin
          w  = $urandom_range(0, seq.size() - 1);
          wv = seq[w] ^ 4'($urandom_range(1, 15));
        end
        responder(w, wv, res);
      end
      if (res == 2)
        hold_fin(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/controlador_secuencia.md
Name: controlador_secuencia

Overview:
Game-sequence controller that sits directly downstream of the random-position counter. It pulses `pedir` to obtain a 4-bit random cell from the counter and appends that cell to a stored sequence. It then replays the sequence on the 4x4 display as timed flashes and checks the player's button presses against it, growing the sequence by one cell per successful round. Outputs drive the display/LED stage and the score/status logic.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it wins the game (range 1..16).
LEN_W, 5, width of the length/index registers; must hold MAX_LEN.
T_ON, 12500000, clk cycles each cell is shown (mostrar=1).
T_OFF, 6250000, clk cycles of blank gap after each shown cell.
CNT_W, 24, width of the display timer; must hold max(T_ON, T_OFF).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset; one clock, synchronous, active-high.
iniciar  in  1  start-game request, sampled high for at least one cycle.
posicion  in  4  random cell from the upstream counter.
boton_valido  in  1  one-cycle pulse: player pressed a cell.
boton_pos  in  4  cell pressed; valid when boton_valido=1.
pedir  out  1  request to the upstream counter; high exactly 1 cycle per new cell.
mostrar  out  1  display enable for celda.
celda  out  4  cell currently displayed.
nivel  out  LEN_W  current sequence length.
esperando  out  1  high while awaiting player input.
acierto  out  1  one-cycle pulse: round completed correctly.
error  out  1  one-cycle pulse: wrong press, game over.
fin  out  1  game won; held high.

Behaviour:
- Storage:
  - Sequence memory is MAX_LEN x 4 bits, indexed by idx (LEN_W bits).
  - Memory contents are not cleared by rst and are don't-care beyond nivel.
- Reset:
  - On rst=1, at the next edge: state=IDLE; pedir, mostrar, esperando, acierto, error, fin = 0; celda=0; nivel=0; idx=0; timer=0.
  - rst takes priority over every other input, including mid-display or mid-input.
- IDLE:
  - All outputs low; nivel holds its last value.
  - iniciar=1 -> nivel<=0, go to PEDIR.
- PEDIR:
  - pedir=1 for this single cycle, then go to ESPERA_RND.
- ESPERA_RND:
  - One wait cycle so the upstream capture settles; go to CAPTURA.
- CAPTURA:
  - mem[nivel] <= posicion; nivel <= nivel+1; idx <= 0; timer <= 0; go to MOSTRAR_ON.
  - posicion is sampled exactly 2 cycles after the pedir cycle.
- MOSTRAR_ON:
  - mostrar=1, celda=mem[idx] for exactly T_ON cycles, then go to MOSTRAR_OFF with timer reset.
- MOSTRAR_OFF:
  - mostrar=0, celda holds, for exactly T_OFF cycles.
  - Then, if idx==nivel-1: idx<=0, go to ENTRADA.
  - Otherwise: idx<=idx+1, go to MOSTRAR_ON.
- ENTRADA:
  - esperando=1; no timeout.
  - On boton_valido with boton_pos==mem[idx]: if idx==nivel-1 go to ACIERTO, else idx<=idx+1.
  - On boton_valido with boton_pos!=mem[idx]: go to ERROR.
- ACIERTO:
  - acierto=1 for one cycle.
  - If nivel==MAX_LEN go to GANADO, else go to PEDIR.
- ERROR:
  - error=1 for one cycle, then go to IDLE; nivel keeps the failed length.
- GANADO:
  - fin=1 held.
  - iniciar=1 -> fin=0, nivel<=0, go to PEDIR.
- Ignored inputs:
  - iniciar is ignored in every state except IDLE and GANADO; there is no restart mid-game.
  - boton_valido is ignored outside ENTRADA, including presses during display.
- Outputs:
  - All outputs are registered.
  - No two of pedir/acierto/error are ever high in the same cycle.
- Timer rules:
  - Counts 0..T-1 and compares against the parameter.
  - T_ON=1 or T_OFF=1 gives single-cycle phases.
  - Arithmetic is unsigned, with no wrap beyond MAX_LEN.

Test Plan:
1. T_ON=4, T_OFF=2, rst then iniciar, posicion=9 -> pedir high 1 cycle after iniciar; nivel=1; mostrar=1 with celda=9 for 4 cycles, 0 for 2; then esperando=1.
2. Continue: boton_valido with boton_pos=9 -> acierto 1-cycle pulse; pedir again; with posicion=3 -> shows 9 then 3, nivel=2; presses 9,3 -> acierto.
3. At nivel=2, press 9 then 5 -> error 1-cycle pulse, esperando=0, state IDLE, nivel stays 2; a further boton_valido has no effect.
4. MAX_LEN=2, two correct rounds -> acierto then fin=1 held for 20 cycles; iniciar -> fin=0, pedir pulse, nivel=1.
5. rst asserted during MOSTRAR_ON -> next cycle mostrar=0, nivel=0, no pedir; boton_valido pulses during display before rst never produce acierto/error.
6. iniciar pulsed during ENTRADA -> ignored: nivel, idx and esperando unchanged; a subsequent correct press completes the round normally.
